turn_signal_input: RTL and testbench
====================================

Name: turn_signal_input

Overview:
- Upstream front end for the taillight sequencer.
- Conditions the raw, asynchronous left/right turn-stalk switches: synchronizes, debounces, and resolves conflicts between them.
- Presents clean level requests `left`/`right` that the sequencer samples in its idle state.
- Also generates `step_en`, a one-cycle step-rate pulse, so the sequencer advances lamp patterns at a visible rate off the system clock.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per switch input (legal range 2..3).
- DB_CYCLES, 16, consecutive synchronized cycles an input must hold a new value before it is accepted (legal range >=2).
- TICK_DIV, 8, clock cycles per `step_en` pulse (legal range >=2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- left_sw  input  1  raw left stalk switch, asynchronous, may bounce.
- right_sw  input  1  raw right stalk switch, asynchronous, may bounce.
- left  output  1  debounced left request, registered.
- right  output  1  debounced right request, registered.
- conflict  output  1  both switches debounced high, registered.
- step_en  output  1  one-cycle step pulse, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchronizer flops, debounced states and debounce counters clear to 0.
  - The tick counter clears to 0.
  - `left`, `right`, `conflict` and `step_en` are all 0.
  - Release is synchronous to the next clk edge.
- Synchronizer: each switch passes through SYNC_STAGES flops; only the last stage feeds the debouncer.
- Debounce, per channel, counter width clog2(DB_CYCLES):
  - If sync value == stable value: counter <= 0.
  - Else if counter == DB_CYCLES-1: stable <= sync value, counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DB_CYCLES synchronized cycles never changes the stable value; any return to the stable value restarts the count.
- Output decode, registered from the stable values:
  - `left` = stable_l & ~stable_r
  - `right` = stable_r & ~stable_l
  - `conflict` = stable_l & stable_r
  - `left` and `right` are never 1 together.
- Latency: a clean switch transition first sampled at edge 1 appears on `left`/`right` after edge SYNC_STAGES+DB_CYCLES+1. Falling transitions have the same latency.
- Tick generator:
  - Counter 0..TICK_DIV-1, wraps to 0.
  - `step_en` = 1 for exactly the cycle after the counter equals TICK_DIV-1, giving period TICK_DIV cycles.
  - Realignment: when `left` or `right` rises (0->1 on the registered output), the counter is forced to 0 on that same edge. The first `step_en` then follows TICK_DIV cycles after the request edge.
  - If realignment coincides with a wrap, realignment wins and no `step_en` fires that cycle.
- Simultaneous events:
  - Both switches becoming stable on the same edge gives `conflict`=1, `left`=`right`=0.
  - When one switch releases, the other's request appears on the next edge, with no extra debounce.
- Reset mid-operation: all outputs drop to 0 immediately. Debounce history is lost, so a held switch must re-qualify for the full latency after release.
- `step_en` runs continuously, even with no request; the sequencer ignores it when idle.

Decomposition:
- Shared package (`thunderbird_pkg`): default constants SYNC_STAGES_DEF, DB_CYCLES_DEF and TICK_DIV_DEF, plus the lamp-pattern constants already used by the sequencer, so both blocks agree on rates.
- One natural sub-module, `switch_debounce` (synchronizer + debounce counter, one channel, parameters SYNC_STAGES and DB_CYCLES), instantiated twice.
- Decode and tick logic stay in the top level.

Test Plan (SYNC_STAGES=2, DB_CYCLES=4, TICK_DIV=3 unless stated):
- Reset check: hold reset=0 with both switches=1 -> all outputs 0; release reset -> `left`/`right` remain 0 until at least 7 edges after release, then `conflict`=1.
- Clean left press: left_sw 0->1 held -> `left`=1 exactly 7 edges after first sampling edge; `right`=`conflict`=0; first `step_en` 3 cycles after `left` rises, then every 3 cycles.
- Bounce rejection: right_sw toggles 1/0 every 2 cycles for 20 cycles, then holds 1 -> `right` stays 0 during bounce; rises 7 edges after the final clean transition.
- Conflict and release: both switches held 1 -> `conflict`=1, `left`=`right`=0; drop left_sw -> `conflict`=0 and `right`=1 exactly 7 edges later.
- Mid-operation reset: `left`=1 with left_sw still 1; pulse reset=0 for 1 cycle asynchronously between edges -> `left`=0 immediately; `left` returns 7 edges after reset release.
- Tick wrap/realign collision: align `left` rise with tick counter at 2 -> no `step_en` that cycle; next `step_en` 3 cycles later; verify `step_en` is never high 2 consecutive cycles (TICK_DIV=2 variant too).

Source files
------------

// File: rtl/thunderbird_pkg.sv
// -----------------------------------------------------------------------------
// thunderbird_pkg
// Shared constants for the taillight front end and the sequencer so both
// blocks agree on rates and lamp patterns.
//   SYNC_STAGES_DEF : synchronizer depth per stalk switch
//   DB_CYCLES_DEF   : synchronized cycles a new switch level must persist
//   TICK_DIV_DEF    : clock cycles per sequencer step pulse
//   LAMP_*          : three-lamp patterns driven by the sequencer
//   req_t           : decoded turn request
//   decode_req()    : resolves the two debounced levels into a request
// -----------------------------------------------------------------------------
package thunderbird_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 16;
    localparam int TICK_DIV_DEF    = 8;

    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_OFF   = 3'b000;
    localparam lamp_t LAMP_ONE   = 3'b001;
    localparam lamp_t LAMP_TWO   = 3'b011;
    localparam lamp_t LAMP_THREE = 3'b111;

    typedef struct packed {
        logic left;
        logic right;
        logic conflict;
    } req_t;

    // Both stalks active is a fault condition: neither direction is granted.
    function automatic req_t decode_req(input logic stable_l, input logic stable_r);
        req_t req;
        req.left     = stable_l & ~stable_r;
        req.right    = stable_r & ~stable_l;
        req.conflict = stable_l & stable_r;
        return req;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// One stalk-switch channel: multi-flop synchronizer followed by a
// consecutive-cycle debouncer.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   sw     : raw asynchronous switch level
//   stable : debounced level (registered)
// -----------------------------------------------------------------------------
import thunderbird_pkg::*;

module switch_debounce #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic stable
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          count_r;
    logic                   stable_r;
    logic                   sync_s;

    // Only the last synchronizer stage is considered metastability-free.
    assign sync_s = sync_r[SYNC_STAGES-1];
    assign stable = stable_r;

    // Synchronizer shift chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sw};
        end
    end

    // Debounce: any return to the stable level restarts qualification.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= CNT_ZERO;
            stable_r <= 1'b0;
        end else if (sync_s == stable_r) begin
            count_r  <= CNT_ZERO;
            stable_r <= stable_r;
        end else if (count_r == DB_LAST) begin
            count_r  <= CNT_ZERO;
            stable_r <= sync_s;
        end else begin
            count_r  <= count_r + CNT_ONE;
            stable_r <= stable_r;
        end
    end

endmodule

// File: rtl/turn_signal_input.sv
// -----------------------------------------------------------------------------
// turn_signal_input
// Front end for the taillight sequencer: conditions the two stalk switches
// into clean, mutually exclusive requests and produces the step-rate pulse.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   left_sw  : raw left stalk switch (asynchronous, bouncy)
//   right_sw : raw right stalk switch (asynchronous, bouncy)
//   left     : debounced left request (registered)
//   right    : debounced right request (registered)
//   conflict : both switches debounced high (registered)
//   step_en  : one-cycle pulse every TICK_DIV cycles (registered)
// -----------------------------------------------------------------------------
import thunderbird_pkg::*;

module turn_signal_input #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int TICK_DIV    = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    output logic left,
    output logic right,
    output logic conflict,
    output logic step_en
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic          stable_left_s;
    logic          stable_right_s;
    req_t          req_s;
    logic          realign_s;
    logic          wrap_s;
    logic          left_r;
    logic          right_r;
    logic          conflict_r;
    logic          step_r;
    logic [TW-1:0] tick_r;

    switch_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_db_left (
        .clk    (clk),
        .reset  (reset),
        .sw     (left_sw),
        .stable (stable_left_s)
    );

    switch_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_db_right (
        .clk    (clk),
        .reset  (reset),
        .sw     (right_sw),
        .stable (stable_right_s)
    );

    // Next request decode and detection of a fresh left/right request, which
    // restarts the step phase so the first lamp step is a full period away.
    always_comb begin
        req_s     = decode_req(stable_left_s, stable_right_s);
        realign_s = (req_s.left & ~left_r) | (req_s.right & ~right_r);
        wrap_s    = (tick_r == TICK_LAST);
    end

    // Registered request outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_r     <= 1'b0;
            right_r    <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            left_r     <= req_s.left;
            right_r    <= req_s.right;
            conflict_r <= req_s.conflict;
        end
    end

    // Step-rate divider; realignment takes priority over a coincident wrap,
    // so a pulse is never issued on the same edge as a new request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_r <= TICK_ZERO;
            step_r <= 1'b0;
        end else if (realign_s) begin
            tick_r <= TICK_ZERO;
            step_r <= 1'b0;
        end else if (wrap_s) begin
            tick_r <= TICK_ZERO;
            step_r <= 1'b1;
        end else begin
            tick_r <= tick_r + TICK_ONE;
            step_r <= 1'b0;
        end
    end

    assign left     = left_r;
    assign right    = right_r;
    assign conflict = conflict_r;
    assign step_en  = step_r;

endmodule

// File: tb/tb_turn_signal_input.sv
// -----------------------------------------------------------------------------
// tb_turn_signal_input
// Directed bench for turn_signal_input with SYNC_STAGES=2, DB_CYCLES=4.
// Two instances share the stimulus: dut_a with TICK_DIV=3 and dut_b with
// TICK_DIV=2. Observed vector is {a.left,a.right,a.conflict,a.step_en,
// b.left,b.right,b.conflict,b.step_en}; expectations are queued with a mask
// before each edge and compared after it.
// -----------------------------------------------------------------------------
module tb_turn_signal_input;

    logic clk;
    logic reset;
    logic left_sw;
    logic right_sw;
    logic a_left, a_right, a_conflict, a_step;
    logic b_left, b_right, b_conflict, b_step;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int r_cyc = 0;

    string      tag_q[$];
    logic [7:0] mask_q[$];
    logic [7:0] val_q[$];

    localparam logic [7:0] M_ALL   = 8'hFF;
    localparam logic [7:0] M_LAMPS = 8'b1110_1110;
    localparam logic [7:0] M_STEPS = 8'b0001_0001;
    localparam logic [7:0] V_NONE  = 8'b0000_0000;
    localparam logic [7:0] V_LEFT  = 8'b1000_1000;
    localparam logic [7:0] V_RIGHT = 8'b0100_0100;
    localparam logic [7:0] V_CONF  = 8'b0010_0010;

    turn_signal_input #(.SYNC_STAGES(2), .DB_CYCLES(4), .TICK_DIV(3)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .left     (a_left),
        .right    (a_right),
        .conflict (a_conflict),
        .step_en  (a_step)
    );

    turn_signal_input #(.SYNC_STAGES(2), .DB_CYCLES(4), .TICK_DIV(2)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .left     (b_left),
        .right    (b_right),
        .conflict (b_conflict),
        .step_en  (b_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {a_left, a_right, a_conflict, a_step, b_left, b_right, b_conflict, b_step};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] mask, input logic [7:0] val);
        tag_q.push_back(tag);
        mask_q.push_back(mask);
        val_q.push_back(val);
    endtask

    task automatic check_out();
        string      tag;
        logic [7:0] mask;
        logic [7:0] val;
        logic [7:0] obs;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            tag  = tag_q.pop_front();
            mask = mask_q.pop_front();
            val  = val_q.pop_front();
            obs  = outs() & mask;
            assert (obs === val) else begin
                bad++;
                $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, val);
            end
        end
    endtask

    task automatic edge_check(input string tag, input logic [7:0] mask, input logic [7:0] val);
        expect_out(tag, mask, val);
        step();
        check_out();
    endtask

    // Expected step pulses n edges after a realign: period 3 for dut_a, 2 for dut_b.
    function automatic logic [7:0] step_pattern(input int n);
        return (((n % 3) == 0) ? 8'h10 : 8'h00) | (((n % 2) == 0) ? 8'h01 : 8'h00);
    endfunction

    initial begin
        reset    = 1'b0;
        left_sw  = 1'b1;
        right_sw = 1'b1;

        // Reset held with both switches active.
        repeat (3) step();
        expect_out("rst_hold", M_ALL, V_NONE);
        check_out();

        // Release: both qualify together, giving conflict at edge 7.
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) edge_check("rst_rel_wait", M_LAMPS, V_NONE);
        edge_check("rst_rel_conflict", M_LAMPS, V_CONF);

        left_sw  = 1'b0;
        right_sw = 1'b0;
        repeat (9) step();
        expect_out("idle", M_LAMPS, V_NONE);
        check_out();

        // Clean left press.
        left_sw = 1'b1;
        for (int i = 1; i <= 6; i++) edge_check("left_wait", M_LAMPS, V_NONE);
        edge_check("left_rise", M_ALL, V_LEFT);
        for (int n = 1; n <= 6; n++) edge_check("left_steps", M_STEPS, step_pattern(n));

        left_sw = 1'b0;
        repeat (8) step();
        expect_out("left_release", M_LAMPS, V_NONE);
        check_out();

        // Bounce on right, then clean hold.
        for (int c = 0; c < 20; c++) begin
            right_sw = ((c % 4) < 2) ? 1'b1 : 1'b0;
            edge_check("bounce_reject", M_LAMPS, V_NONE);
        end
        right_sw = 1'b1;
        for (int i = 1; i <= 6; i++) edge_check("bounce_wait", M_LAMPS, V_NONE);
        edge_check("bounce_rise", M_LAMPS, V_RIGHT);

        // Conflict, then release left so right returns without re-debounce.
        left_sw = 1'b1;
        for (int i = 1; i <= 6; i++) edge_check("conf_wait", M_LAMPS, V_RIGHT);
        edge_check("conf_set", M_LAMPS, V_CONF);
        left_sw = 1'b0;
        for (int i = 1; i <= 6; i++) edge_check("conf_hold", M_LAMPS, V_CONF);
        edge_check("conf_release", M_LAMPS, V_RIGHT);

        // Swap stalks on the same cycle.
        right_sw = 1'b0;
        left_sw  = 1'b1;
        for (int i = 1; i <= 6; i++) edge_check("swap_wait", M_LAMPS, V_RIGHT);
        edge_check("swap_left", M_ALL, V_LEFT);

        // Asynchronous reset pulse between edges.
        reset = 1'b0;
        #3;
        expect_out("rst_async", M_ALL, V_NONE);
        check_out();
        step();
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) edge_check("rst_requal_wait", M_LAMPS, V_NONE);
        edge_check("rst_requal_left", M_ALL, V_LEFT);
        r_cyc = cyc;

        // Wrap/realign collision for both divider settings.
        left_sw = 1'b0;
        repeat (8) step();
        for (int k = 0; k < 6; k++) begin
            if (((cyc + 7 - r_cyc) % 6) != 0) step();
        end
        left_sw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            edge_check("pre_collide_steps", M_STEPS,
                       (((k == 1) || (k == 4)) ? 8'h10 : 8'h00) | (((k % 2) == 1) ? 8'h01 : 8'h00));
        end
        edge_check("collide_suppress", M_ALL, V_LEFT);
        for (int n = 1; n <= 6; n++) edge_check("post_collide_steps", M_STEPS, step_pattern(n));

        // step_en never high on two consecutive cycles.
        for (int n = 0; n < 12; n++) begin
            logic pa, pb;
            pa = a_step;
            pb = b_step;
            step();
            total++;
            assert (!(pa && a_step) && !(pb && b_step)) else begin
                bad++;
                $error("FAIL step_double cyc=%0d observed=%b%b/%b%b expected=no 11", cyc, pa, a_step, pb, b_step);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
